sys_3by3_result_collector: RTL and testbench

//  Result-side counterpart of the 3x3 systolic-array address controller.
//  - The controller sequences operand reads; this block captures the 2x2 output results (C11,C12,C21,C22) from the array.
//  - It holds them in a 4-entry result buffer and serves the controller's buffer_read_addr during the display phase.
//  - It provides done/valid status plus a sign/magnitude split for the display path.

---
 rtl/sys_3by3_pkg.sv | 26 ++
 rtl/result_buffer_2by2.sv | 82 ++++++++
 rtl/sys_3by3_result_collector.sv | 169 ++++++++++++++++
 tb/tb_sys_3by3_result_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_3by3_pkg.sv
// Shared definitions for the 3x3 systolic-array address controller and the
// result collector. Both sides import this package so they agree on feed and
// drain timing, on FSM encodings and on result-buffer addresses.
//   No ports: constants only.
package sys_3by3_pkg;

  // Default datapath and timing. The controller keeps sys_en high for
  // FEED_CYCLES of operand feed and then DRAIN_CYCLES more until the last
  // PE result (C22) has settled.
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_FEED_CYCLES  = 12;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_CNT_W        = 5;

  // Result collector FSM encoding.
  localparam logic [1:0] COL_IDLE = 2'd0;
  localparam logic [1:0] COL_RUN  = 2'd1;
  localparam logic [1:0] COL_HOLD = 2'd2;

  // Result buffer addresses, as driven by the controller during display.
  localparam logic [1:0] ADDR_C11 = 2'd0;
  localparam logic [1:0] ADDR_C12 = 2'd1;
  localparam logic [1:0] ADDR_C21 = 2'd2;
  localparam logic [1:0] ADDR_C22 = 2'd3;

endpackage

// File: rtl/result_buffer_2by2.sv
// Four-entry result store for the 2x2 output block (C11, C12, C21, C22).
// All four entries are written together in one cycle; one registered read
// port returns zero whenever reading is not enabled.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high clear of all entries and rd_data
//   wr_en    in   capture all four wr_data_* inputs on this edge
//   wr_data_11/12/21/22  in  DATA_W  values to capture
//   rd_en    in   when low the read register loads zero
//   rd_addr  in   2  entry select (ADDR_C11..ADDR_C22)
//   rd_data  out  DATA_W  registered read data (1-cycle latency)
module result_buffer_2by2
  import sys_3by3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data_11,
  input  logic [DATA_W-1:0] wr_data_12,
  input  logic [DATA_W-1:0] wr_data_21,
  input  logic [DATA_W-1:0] wr_data_22,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] entry_11_r;
  logic [DATA_W-1:0] entry_12_r;
  logic [DATA_W-1:0] entry_21_r;
  logic [DATA_W-1:0] entry_22_r;
  logic [DATA_W-1:0] rd_sel_s;
  logic [DATA_W-1:0] rd_data_r;

  // Entry storage: plain copy of all four results on a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_11_r <= ZERO;
      entry_12_r <= ZERO;
      entry_21_r <= ZERO;
      entry_22_r <= ZERO;
    end else if (wr_en) begin
      entry_11_r <= wr_data_11;
      entry_12_r <= wr_data_12;
      entry_21_r <= wr_data_21;
      entry_22_r <= wr_data_22;
    end else begin
      entry_11_r <= entry_11_r;
      entry_12_r <= entry_12_r;
      entry_21_r <= entry_21_r;
      entry_22_r <= entry_22_r;
    end
  end

  // Read address decode.
  always_comb begin
    rd_sel_s = ZERO;
    case (rd_addr)
      ADDR_C11: rd_sel_s = entry_11_r;
      ADDR_C12: rd_sel_s = entry_12_r;
      ADDR_C21: rd_sel_s = entry_21_r;
      ADDR_C22: rd_sel_s = entry_22_r;
      default:  rd_sel_s = ZERO;
    endcase
  end

  // Registered read port; gated to zero so stale data never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= ZERO;
    end else if (rd_en) begin
      rd_data_r <= rd_sel_s;
    end else begin
      rd_data_r <= ZERO;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sys_3by3_result_collector.sv
// Result-side counterpart of the 3x3 systolic-array address controller.
// Counts sys_en-high cycles, captures the four PE results once feed and drain
// are complete, holds them for the display phase and serves reads by address,
// with a sign/magnitude split of the read data for the display path.
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset (clears buffer too)
//   sys_en            in   array enable from the controller
//   pe_out_11/12/21/22 in  DATA_W  PE results (two's complement)
//   buffer_read_addr  in   2  00=C11 01=C12 10=C21 11=C22
//   buffer_read_data  out  DATA_W  registered read data, zero unless in HOLD
//   read_neg          out  sign bit of buffer_read_data
//   read_mag          out  DATA_W  |buffer_read_data|, most-negative saturates
//   done              out  high while results are held (HOLD)
//   busy              out  high while counting toward capture (RUN)
module sys_3by3_result_collector
  import sys_3by3_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FEED_CYCLES  = DEF_FEED_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sys_en,
  input  logic [DATA_W-1:0] pe_out_11,
  input  logic [DATA_W-1:0] pe_out_12,
  input  logic [DATA_W-1:0] pe_out_21,
  input  logic [DATA_W-1:0] pe_out_22,
  input  logic [1:0]        buffer_read_addr,
  output logic [DATA_W-1:0] buffer_read_data,
  output logic              read_neg,
  output logic [DATA_W-1:0] read_mag,
  output logic              done,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CAPTURE_CNT = CNT_W'(FEED_CYCLES + DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MOST_NEG    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DATA_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              capture_s;
  logic              read_en_s;
  logic              done_s;
  logic              busy_s;
  logic [DATA_W-1:0] read_data_s;

  // Two's-complement magnitude; the most-negative value has no positive
  // counterpart in DATA_W bits, so it clamps to the largest positive value.
  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v == MOST_NEG) begin
      r = MOST_POS;
    end else if (v[DATA_W-1]) begin
      r = ~v + DATA_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // State and cycle-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= COL_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state, counter and capture decision. A drop of sys_en in any state
  // returns to IDLE; HOLD never recaptures, so a new run needs sys_en low.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      COL_IDLE: begin
        if (sys_en) begin
          state_next_s = COL_RUN;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = COL_IDLE;
          cnt_next_s   = CNT_ZERO;
        end
      end
      COL_RUN: begin
        if (!sys_en) begin
          state_next_s = COL_IDLE;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CAPTURE_CNT) begin
          state_next_s = COL_HOLD;
          cnt_next_s   = cnt_r;
          capture_s    = 1'b1;
        end else begin
          state_next_s = COL_RUN;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      COL_HOLD: begin
        if (!sys_en) begin
          state_next_s = COL_IDLE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = COL_HOLD;
          cnt_next_s   = cnt_r;
        end
      end
      default: begin
        state_next_s = COL_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Status decode straight from the state register.
  always_comb begin
    done_s    = 1'b0;
    busy_s    = 1'b0;
    read_en_s = 1'b0;
    case (state_r)
      COL_RUN: begin
        busy_s = 1'b1;
      end
      COL_HOLD: begin
        done_s    = 1'b1;
        read_en_s = 1'b1;
      end
      default: begin
        done_s    = 1'b0;
        busy_s    = 1'b0;
        read_en_s = 1'b0;
      end
    endcase
  end

  // Read uses the current state, so the read on the capture edge itself
  // still sees RUN and returns zero.
  result_buffer_2by2 #(
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (capture_s),
    .wr_data_11 (pe_out_11),
    .wr_data_12 (pe_out_12),
    .wr_data_21 (pe_out_21),
    .wr_data_22 (pe_out_22),
    .rd_en      (read_en_s),
    .rd_addr    (buffer_read_addr),
    .rd_data    (read_data_s)
  );

  assign buffer_read_data = read_data_s;
  assign read_neg         = read_data_s[DATA_W-1];
  assign read_mag         = sat_abs(read_data_s);
  assign done             = done_s;
  assign busy             = busy_s;

endmodule

// File: tb/tb_sys_3by3_result_collector.sv
// Self-checking bench for sys_3by3_result_collector: a directed vector table,
// hand-written reset corner cases, then randomized traffic, all compared
// every cycle against a streak-based reference model.
module tb_sys_3by3_result_collector;

  localparam int DW  = 16;
  // A capture happens on the edge that completes this many consecutive
  // sys_en-high edges: the IDLE->RUN edge plus FEED+DRAIN counting edges.
  localparam int CAP = 12 + 4 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sys_en;
  logic [DW-1:0] pe11, pe12, pe21, pe22;
  logic [1:0]    addr;
  logic [DW-1:0] rd_data;
  logic          rd_neg;
  logic [DW-1:0] rd_mag;
  logic          done;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int            m_streak;
  logic [DW-1:0] m_buf [4];
  logic [DW-1:0] m_rd;

  typedef struct {
    string         name;
    logic          en;
    logic [1:0]    addr;
    logic [DW-1:0] p11, p12, p21, p22;
    int            cycles;
    logic          exp_done;
    logic          exp_busy;
    logic [DW-1:0] exp_rd;
    logic          exp_neg;
    logic [DW-1:0] exp_mag;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  sys_3by3_result_collector dut (
    .clk              (clk),
    .rst              (rst),
    .sys_en           (sys_en),
    .pe_out_11        (pe11),
    .pe_out_12        (pe12),
    .pe_out_21        (pe21),
    .pe_out_22        (pe22),
    .buffer_read_addr (addr),
    .buffer_read_data (rd_data),
    .read_neg         (rd_neg),
    .read_mag         (rd_mag),
    .done             (done),
    .busy             (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    for (int i = 0; i < 4; i++) m_buf[i] = '0;
    m_rd = '0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [DW-1:0] rd_n;
    rd_n = (m_streak >= CAP) ? m_buf[addr] : '0;
    if (sys_en) begin
      m_streak++;
      if (m_streak == CAP) begin
        m_buf[0] = pe11;
        m_buf[1] = pe12;
        m_buf[2] = pe21;
        m_buf[3] = pe22;
      end
    end else begin
      m_streak = 0;
    end
    m_rd = rd_n;
  endtask

  task automatic check_model(input string tag);
    int sv;
    int mag;
    sv  = int'($signed(m_rd));
    mag = (sv < 0) ? -sv : sv;
    if (mag > 32767) mag = 32767;
    chk({tag, ".rd"},   32'(rd_data), 32'(m_rd));
    chk({tag, ".neg"},  32'(rd_neg),  32'(sv < 0));
    chk({tag, ".mag"},  32'(rd_mag),  32'(mag));
    chk({tag, ".done"}, 32'(done),    32'(m_streak >= CAP));
    chk({tag, ".busy"}, 32'(busy),    32'(m_streak >= 1 && m_streak < CAP));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic set_pe(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    pe11 = a; pe12 = b; pe21 = c; pe22 = d;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, ".rd_now"},   32'(rd_data), 32'h0);
    chk({tag, ".done_now"}, 32'(done),    32'h0);
    chk({tag, ".busy_now"}, 32'(busy),    32'h0);
    chk({tag, ".mag_now"},  32'(rd_mag),  32'h0);
    sys_en = 1'b0;
    tick({tag, ".held"});
    tick({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    sys_en = 1'b0;
    addr   = 2'd0;
    set_pe(16'h0, 16'h0, 16'h0, 16'h0);
    model_reset();
    tick("rst");
    tick("rst");
    rst = 1'b0;

    // name, en, addr, p11, p12, p21, p22, cycles, done, busy, rd, neg, mag
    tbl.push_back('{"idle5",     1'b0, 2'd0, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"run16",     1'b1, 2'd0, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF, 16, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"capture",   1'b1, 2'd0, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"rd_c11",    1'b1, 2'd0, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  1, 1'b1, 1'b0, 16'h0005, 1'b0, 16'h0005});
    tbl.push_back('{"rd_c12",    1'b1, 2'd1, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  1, 1'b1, 1'b0, 16'hFFFD, 1'b1, 16'h0003});
    tbl.push_back('{"rd_c21",    1'b1, 2'd2, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  1, 1'b1, 1'b0, 16'h0007, 1'b0, 16'h0007});
    tbl.push_back('{"rd_c22",    1'b1, 2'd3, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  1, 1'b1, 1'b0, 16'h7FFF, 1'b0, 16'h7FFF});
    tbl.push_back('{"leave",     1'b0, 2'd3, 16'd5, 16'hFFFD, 16'd7, 16'h7FFF,  2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"abort_run", 1'b1, 2'd0, 16'd9, 16'd9,    16'd9, 16'd9,     8, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"aborted",   1'b0, 2'd0, 16'd9, 16'd9,    16'd9, 16'd9,     1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"run17",     1'b1, 2'd0, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 17, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{"most_neg",  1'b1, 2'd0, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234,  1, 1'b1, 1'b0, 16'h8000, 1'b1, 16'h7FFF});
    tbl.push_back('{"hold_c12",  1'b1, 2'd1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,  2, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h0001});
    tbl.push_back('{"hold_c21",  1'b1, 2'd2, 16'h1111, 16'h2222, 16'h3333, 16'h4444,  1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 16'h0001});
    tbl.push_back('{"hold_c22",  1'b1, 2'd3, 16'h5555, 16'h6666, 16'h7777, 16'h0F0F,  1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h1234});
    tbl.push_back('{"exit",      1'b0, 2'd3, 16'h0,    16'h0,    16'h0,    16'h0,     2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});

    foreach (tbl[i]) begin
      sys_en = tbl[i].en;
      addr   = tbl[i].addr;
      set_pe(tbl[i].p11, tbl[i].p12, tbl[i].p21, tbl[i].p22);
      for (int c = 0; c < tbl[i].cycles; c++) tick(tbl[i].name);
      chk({tbl[i].name, ".tbl_done"}, 32'(done),    32'(tbl[i].exp_done));
      chk({tbl[i].name, ".tbl_busy"}, 32'(busy),    32'(tbl[i].exp_busy));
      chk({tbl[i].name, ".tbl_rd"},   32'(rd_data), 32'(tbl[i].exp_rd));
      chk({tbl[i].name, ".tbl_neg"},  32'(rd_neg),  32'(tbl[i].exp_neg));
      chk({tbl[i].name, ".tbl_mag"},  32'(rd_mag),  32'(tbl[i].exp_mag));
    end

    // Reset in the middle of a run.
    sys_en = 1'b1;
    addr   = 2'd2;
    set_pe(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    for (int c = 0; c < 10; c++) tick("run10");
    chk("run10.busy_pre", 32'(busy), 32'h1);
    async_reset("rst_run");
    for (int c = 0; c < 3; c++) tick("post_rst_run");

    // Reset while results are held.
    sys_en = 1'b1;
    for (int c = 0; c < CAP + 2; c++) tick("to_hold");
    chk("to_hold.rd_pre",   32'(rd_data), 32'h0303);
    chk("to_hold.done_pre", 32'(done),    32'h1);
    async_reset("rst_hold");
    for (int c = 0; c < 3; c++) tick("post_rst_hold");
    chk("post_rst_hold.rd", 32'(rd_data), 32'h0);

    // Randomized traffic: sys_en mostly high so many runs reach capture.
    for (int c = 0; c < 1500; c++) begin
      sys_en = ($urandom_range(0, 29) != 0);
      addr   = 2'($urandom_range(0, 3));
      set_pe(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 15) == 0) pe11 = 16'h8000;
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
